// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-through bypass, load-use hazard stall,
// single-entry decode/execute output register and branch-if-equal resolution.
module decode_stage_pipe #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 12,
  parameter int NREG    = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       i_inst,
  input  logic [PC_W-1:0]   pcD,
  input  logic              branchD,
  input  logic              immediateC,
  input  logic              wb_en,
  input  logic [3:0]        wb_add,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_load,
  input  logic [3:0]        ex_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        destadd,
  output logic [DATA_W-1:0] srcdata1,
  output logic [DATA_W-1:0] srcdata2,
  output logic [PC_W-1:0]   pcE,
  output logic              branch_taken,
  output logic [PC_W-1:0]   PC_branch
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] regs [NREG];
  logic [IW-1:0]     rs1_idx, rs2_idx, wb_idx, ex_idx;
  logic [DATA_W-1:0] op1, op2, rs2_val, imm_val;
  logic [PC_W-1:0]   br_target;
  logic              hazard, accept, wb_blocked, ex_is_zero;
  logic              unused_bits;

  assign rs1_idx     = i_inst[8 +: IW];
  assign rs2_idx     = i_inst[4 +: IW];
  assign wb_idx      = wb_add[IW-1:0];
  assign ex_idx      = ex_rd[IW-1:0];
  assign unused_bits = ^{i_inst[15:12], wb_add, ex_rd};

  assign wb_blocked = (R0_ZERO != 0) && (wb_idx == '0);
  assign ex_is_zero = (R0_ZERO != 0) && (ex_idx == '0);

  // Register reads see a same-cycle writeback so the retried instruction never
  // needs an extra cycle after the producer retires.
  always_comb begin
    op1 = regs[rs1_idx];
    if (wb_en && wb_idx == rs1_idx) op1 = wb_data;
    if (R0_ZERO != 0 && rs1_idx == '0) op1 = '0;
    rs2_val = regs[rs2_idx];
    if (wb_en && wb_idx == rs2_idx) rs2_val = wb_data;
    if (R0_ZERO != 0 && rs2_idx == '0) rs2_val = '0;
  end

  assign imm_val   = {{(DATA_W-4){i_inst[7]}}, i_inst[7:4]};
  assign op2       = immediateC ? imm_val : rs2_val;
  assign br_target = pcD + PC_W'(1) + {{(PC_W-4){i_inst[3]}}, i_inst[3:0]};

  assign hazard   = ex_load && !ex_is_zero &&
                    ((ex_idx == rs1_idx) || (!immediateC && ex_idx == rs2_idx));
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && !wb_blocked) begin
      regs[wb_idx] <= wb_data;
    end
  end

  // Branches resolve here and never occupy the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      destadd      <= '0;
      srcdata1     <= '0;
      srcdata2     <= '0;
      pcE          <= '0;
      branch_taken <= 1'b0;
      PC_branch    <= '0;
    end else begin
      branch_taken <= 1'b0;
      if (accept && !branchD) begin
        out_valid <= 1'b1;
        destadd   <= i_inst[3:0];
        srcdata1  <= op1;
        srcdata2  <= op2;
        pcE       <= pcD;
      end else if (accept) begin
        out_valid <= 1'b0;
        if (op1 == op2) begin
          branch_taken <= 1'b1;
          PC_branch    <= br_target;
        end
      end else if (!out_valid || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed vector table, hand-written
// reset sequences, then randomized traffic against a behavioural model.
module tb_decode_stage_pipe;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [15:0] i_inst;
  logic [11:0] pcD;
  logic        branchD, immediateC;
  logic        wb_en;
  logic [3:0]  wb_add;
  logic [15:0] wb_data;
  logic        ex_load;
  logic [3:0]  ex_rd;
  logic        out_valid, out_ready;
  logic [3:0]  destadd;
  logic [15:0] srcdata1, srcdata2;
  logic [11:0] pcE;
  logic        branch_taken;
  logic [11:0] PC_branch;

  int nChecks = 0;
  int nFails  = 0;

  decode_stage_pipe #(.DATA_W(16), .PC_W(12), .NREG(16), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .i_inst(i_inst), .pcD(pcD), .branchD(branchD), .immediateC(immediateC),
    .wb_en(wb_en), .wb_add(wb_add), .wb_data(wb_data),
    .ex_load(ex_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .destadd(destadd), .srcdata1(srcdata1), .srcdata2(srcdata2), .pcE(pcE),
    .branch_taken(branch_taken), .PC_branch(PC_branch)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic [15:0] inst;
    logic [11:0] pc;
    logic        br, imm, wbe;
    logic [3:0]  wba;
    logic [15:0] wbd;
    logic        exl;
    logic [3:0]  exr;
    logic        ordy;
    logic        eRdy, eVal;
    logic [3:0]  eDest;
    logic [15:0] eS1, eS2;
    logic [11:0] ePce;
    logic        eBt;
    logic [11:0] ePcb;
  } vec_t;

  vec_t vecs [21];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid   = v.iv;
    i_inst     = v.inst;
    pcD        = v.pc;
    branchD    = v.br;
    immediateC = v.imm;
    wb_en      = v.wbe;
    wb_add     = v.wba;
    wb_data    = v.wbd;
    ex_load    = v.exl;
    ex_rd      = v.exr;
    out_ready  = v.ordy;
  endtask

  task automatic checkRegs(input string tag, input logic v, input logic [3:0] d,
                           input logic [15:0] s1, input logic [15:0] s2, input logic [11:0] pe,
                           input logic bt, input logic [11:0] pb);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, " destadd"}, 32'(destadd), 32'(d));
    checkOutput({tag, " srcdata1"}, 32'(srcdata1), 32'(s1));
    checkOutput({tag, " srcdata2"}, 32'(srcdata2), 32'(s2));
    checkOutput({tag, " pcE"}, 32'(pcE), 32'(pe));
    checkOutput({tag, " branch_taken"}, 32'(branch_taken), 32'(bt));
    checkOutput({tag, " PC_branch"}, 32'(PC_branch), 32'(pb));
  endtask

  // Behavioural reference: architectural register values plus the output record.
  logic [15:0] mRegs [16];
  logic        mValid, mBt;
  logic [3:0]  mDest;
  logic [15:0] mS1, mS2;
  logic [11:0] mPce, mPcb;

  function automatic logic [15:0] modelRead(input logic [3:0] f);
    if (f == 0) return 16'h0;
    if (wb_en && wb_add == f) return wb_data;
    return mRegs[f];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = 16'h0;
    mValid = 0; mBt = 0; mDest = 0; mS1 = 0; mS2 = 0; mPce = 0; mPcb = 0;
  endtask

  task automatic randomCycle();
    vec_t v;
    logic hz, rdy, acc;
    logic [15:0] o1, o2;
    v.iv   = ($urandom_range(0, 9) < 7);
    v.inst = {4'($urandom), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom)};
    v.pc   = 12'($urandom);
    v.br   = ($urandom_range(0, 4) == 0);
    v.imm  = ($urandom_range(0, 2) == 0);
    v.wbe  = $urandom_range(0, 1);
    v.wba  = 4'($urandom_range(0, 4));
    v.wbd  = ($urandom_range(0, 1) == 1) ? 16'h0009 : 16'($urandom);
    v.exl  = ($urandom_range(0, 3) == 0);
    v.exr  = 4'($urandom_range(0, 4));
    v.ordy = ($urandom_range(0, 9) < 7);
    applyStimulus(v);
    #3;
    hz  = ex_load && ex_rd != 0 &&
          (ex_rd == i_inst[11:8] || (!immediateC && ex_rd == i_inst[7:4]));
    rdy = !hz && (!mValid || out_ready);
    acc = in_valid && rdy;
    checkOutput("rand in_ready", 32'(in_ready), 32'(rdy));
    o1 = modelRead(i_inst[11:8]);
    o2 = immediateC ? 16'($signed(i_inst[7:4])) : modelRead(i_inst[7:4]);
    mBt = 0;
    if (acc && !branchD) begin
      mValid = 1; mDest = i_inst[3:0]; mS1 = o1; mS2 = o2; mPce = pcD;
    end else if (acc) begin
      mValid = 0;
      if (o1 == o2) begin
        mBt  = 1;
        mPcb = 12'(pcD + 1 + 12'($signed(i_inst[3:0])));
      end
    end else if (!mValid || out_ready) begin
      mValid = 0;
    end
    if (wb_en && wb_add != 0) mRegs[wb_add] = wb_data;
    @(posedge clk); #1;
    checkRegs("rand", mValid, mDest, mS1, mS2, mPce, mBt, mPcb);
  endtask

  initial begin
    vec_t idle;
    //           iv inst    pc     br imm wbe wba wbd     exl exr ordy| rdy val dst s1      s2      pce    bt pcb
    vecs[0]  = '{0, 16'h0000, 12'h000, 0, 0, 1, 3, 16'h1234, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 16'h0000, 12'h000, 0, 12'h000};
    vecs[1]  = '{1, 16'h0305, 12'h020, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 4'h5, 16'h1234, 16'h0000, 12'h020, 0, 12'h000};
    vecs[2]  = '{1, 16'h0732, 12'h021, 0, 0, 1, 7, 16'hBEEF, 0, 0, 1, 1, 1, 4'h2, 16'hBEEF, 16'h1234, 12'h021, 0, 12'h000};
    vecs[3]  = '{1, 16'h0401, 12'h022, 0, 0, 0, 0, 16'h0000, 1, 4, 1, 0, 0, 4'h2, 16'hBEEF, 16'h1234, 12'h021, 0, 12'h000};
    vecs[4]  = '{1, 16'h0401, 12'h022, 0, 0, 0, 0, 16'h0000, 0, 4, 1, 1, 1, 4'h1, 16'h0000, 16'h0000, 12'h022, 0, 12'h000};
    vecs[5]  = '{1, 16'h0401, 12'h022, 0, 0, 1, 4, 16'h4444, 1, 4, 1, 0, 0, 4'h1, 16'h0000, 16'h0000, 12'h022, 0, 12'h000};
    vecs[6]  = '{1, 16'h0401, 12'h022, 0, 0, 1, 4, 16'h5555, 0, 0, 1, 1, 1, 4'h1, 16'h5555, 16'h0000, 12'h022, 0, 12'h000};
    vecs[7]  = '{1, 16'h0386, 12'h023, 0, 1, 0, 0, 16'h0000, 1, 5, 1, 1, 1, 4'h6, 16'h1234, 16'hFFF8, 12'h023, 0, 12'h000};
    vecs[8]  = '{1, 16'h0309, 12'h024, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 1, 1, 4'h9, 16'h1234, 16'h0000, 12'h024, 0, 12'h000};
    vecs[9]  = '{1, 16'h000A, 12'h025, 0, 0, 1, 0, 16'hFFFF, 0, 0, 1, 1, 1, 4'hA, 16'h0000, 16'h0000, 12'h025, 0, 12'h000};
    vecs[10] = '{0, 16'h0000, 12'h000, 0, 0, 1, 1, 16'h0009, 0, 0, 1, 1, 0, 4'hA, 16'h0000, 16'h0000, 12'h025, 0, 12'h000};
    vecs[11] = '{1, 16'h012E, 12'h010, 1, 0, 1, 2, 16'h0009, 0, 0, 1, 1, 0, 4'hA, 16'h0000, 16'h0000, 12'h025, 1, 12'h00F};
    vecs[12] = '{0, 16'h0000, 12'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 4'hA, 16'h0000, 16'h0000, 12'h025, 0, 12'h00F};
    vecs[13] = '{1, 16'h0132, 12'h050, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 4'hA, 16'h0000, 16'h0000, 12'h025, 0, 12'h00F};
    vecs[14] = '{1, 16'h0123, 12'hFFF, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 4'hA, 16'h0000, 16'h0000, 12'h025, 1, 12'h003};
    vecs[15] = '{1, 16'h0120, 12'h030, 1, 0, 0, 0, 16'h0000, 1, 2, 1, 0, 0, 4'hA, 16'h0000, 16'h0000, 12'h025, 0, 12'h003};
    vecs[16] = '{1, 16'h0134, 12'h060, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 4'h4, 16'h0009, 16'h1234, 12'h060, 0, 12'h003};
    vecs[17] = '{1, 16'h0215, 12'h061, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 4'h4, 16'h0009, 16'h1234, 12'h060, 0, 12'h003};
    vecs[18] = vecs[17];
    vecs[19] = vecs[17];
    vecs[20] = '{1, 16'h0215, 12'h061, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 4'h5, 16'h0009, 16'h0009, 12'h061, 0, 12'h003};
    idle = '{0, 16'h0000, 12'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 16'h0000, 12'h000, 0, 12'h000};

    reset = 0;
    applyStimulus(idle);
    #2;
    checkRegs("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    #6 reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      #3;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].eRdy));
      @(posedge clk); #1;
      checkRegs($sformatf("vec%0d", i), vecs[i].eVal, vecs[i].eDest, vecs[i].eS1,
                vecs[i].eS2, vecs[i].ePce, vecs[i].eBt, vecs[i].ePcb);
    end

    // Reset while the output register is stalled holding a valid instruction.
    applyStimulus(vecs[17]);
    @(posedge clk); #1;
    checkOutput("stall hold out_valid", 32'(out_valid), 32'd1);
    #2 reset = 0;
    #1;
    checkRegs("async reset mid-stall", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    // Reset during a branch pulse: r1 == r2 == 0 after reset, so the branch is taken.
    applyStimulus('{1, 16'h0120, 12'h100, 1, 0, 0, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    checkOutput("post-reset branch_taken", 32'(branch_taken), 32'd1);
    checkOutput("post-reset PC_branch", 32'(PC_branch), 32'h101);
    applyStimulus(idle);
    #2 reset = 0;
    #1;
    checkOutput("reset kills pulse", 32'(branch_taken), 32'd0);
    checkOutput("reset clears PC_branch", 32'(PC_branch), 32'd0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    // Register file must have been cleared: r3 previously held 0x1234.
    applyStimulus('{1, 16'h0300, 12'h077, 0, 0, 0, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    checkRegs("regfile cleared", 1, 0, 0, 0, 12'h077, 0, 0);

    applyStimulus(idle);
    reset = 0;
    modelReset();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) randomCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
